// File: rtl/tile_sched_ctrl_pkg.sv
// Shared definitions for the tile scheduler: default geometry, FSM state
// encodings and the row-major tile address helper.
package tile_sched_ctrl_pkg;

    // Default geometry: 8x8 matrix, 4x4 array, 8-bit buffer addresses.
    localparam int unsigned ROW_M_DEF      = 8;
    localparam int unsigned ROW_A_DEF      = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    // Scheduler phases. A job walks LOAD_A -> LOAD_W -> COMPUTE for every
    // reduction tile k. It then drains the accumulators in DELOAD before it
    // moves on to the next output tile.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_W  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DELOAD  = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_e;

    // Row-major element address of beat `beat` inside tile row `tile`.
    // The buffer holds `tiles` tile columns per element row.
    // The caller truncates the result to the buffer address width.
    function automatic logic [31:0] tile_addr(input int unsigned tile,
                                              input int unsigned beat,
                                              input int unsigned col,
                                              input int unsigned edge_len,
                                              input int unsigned tiles);
        return 32'((tile * edge_len + beat) * tiles + col);
    endfunction

endpackage

// File: rtl/tile_sched_ctrl_loop_cnt.sv
// tile_loop_cnt: a wrapping up-counter with a run-time terminal value,
// an enable and a synchronous clear. The scheduler instantiates it for the
// i, j, k and beat (r) loop indices.
module tile_loop_cnt
    import tile_sched_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Terminal count means the next enabled step wraps back to zero.
    assign tc    = (count_q == max_val);
    assign count = count_q;

    // Clear wins over enable. When enabled, the counter either steps or wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tile_sched_ctrl.sv
// tile_sched_ctrl: sequences tiled matrix multiplication on a ROW_A x ROW_A
// systolic array. For every output tile (i, j) it loops over the reduction
// tiles k. Each k loads an A tile, then a W tile, then runs the compute wave.
// The accumulated result is drained once k is exhausted.
// Optional feature: define SCHED_PERF_CNT_EN to add a 32-bit cycle_count
// output that measures job length, stalls included.
module tile_sched_ctrl
    import tile_sched_ctrl_pkg::*;
#(
    parameter int ROW_M      = ROW_M_DEF,
    parameter int ROW_A      = ROW_A_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     load_a,
    output logic                     load_w,
    output logic                     compute,
    output logic                     deload_out,
    output logic                     clear_acc,
    output logic [ADDR_WIDTH-1:0]    addr_a,
    output logic [ADDR_WIDTH-1:0]    addr_w,
    output logic [ADDR_WIDTH-1:0]    addr_res,
    output logic [$clog2(ROW_M)-1:0] index_i,
    output logic [$clog2(ROW_M)-1:0] index_j,
    output logic [$clog2(ROW_M)-1:0] index_k,
    output logic [$clog2(ROW_M)-1:0] index_r
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]              cycle_count
`endif
);

    // Number of tiles along each matrix edge.
    localparam int T     = ROW_M / ROW_A;
    localparam int IDX_W = $clog2(ROW_M);
    // The beat counter must reach 3*ROW_A-3 in COMPUTE, which can exceed
    // ROW_M-1 for small T. It is therefore sized independently of the
    // index outputs.
    localparam int R_W   = $clog2(3 * ROW_A);

    localparam logic [IDX_W-1:0] TILE_MAX = IDX_W'(T - 1);
    localparam logic [R_W-1:0]   LOAD_MAX = R_W'(ROW_A - 1);
    localparam logic [R_W-1:0]   COMP_MAX = R_W'(3 * ROW_A - 3);

    sched_state_e state_q;
    sched_state_e state_d;

    logic start_prev_q;
    logic start_prev_d;
    logic start_edge;

    logic cnt_clear;
    logic i_en;
    logic j_en;
    logic k_en;
    logic r_en;
    logic i_tc;
    logic j_tc;
    logic k_tc;
    logic r_tc;
    logic [IDX_W-1:0] i_cnt;
    logic [IDX_W-1:0] j_cnt;
    logic [IDX_W-1:0] k_cnt;
    logic [R_W-1:0]   r_cnt;
    logic [R_W-1:0]   r_max;

    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_w_q;
    logic [ADDR_WIDTH-1:0] addr_w_d;
    logic [ADDR_WIDTH-1:0] addr_res_q;
    logic [ADDR_WIDTH-1:0] addr_res_d;

    // A job launches only when start rises. A level-held start never
    // relaunches a job.
    assign start_edge   = start & ~start_prev_q;
    assign start_prev_d = start;

    // The beat counter wraps at the length of whichever phase is active.
    assign r_max = (state_q == ST_COMPUTE) ? COMP_MAX : LOAD_MAX;

    tile_loop_cnt #(.WIDTH(IDX_W)) u_cnt_i (
        .clk(clk), .reset(reset), .clear(cnt_clear), .en(i_en),
        .max_val(TILE_MAX), .count(i_cnt), .tc(i_tc)
    );

    tile_loop_cnt #(.WIDTH(IDX_W)) u_cnt_j (
        .clk(clk), .reset(reset), .clear(cnt_clear), .en(j_en),
        .max_val(TILE_MAX), .count(j_cnt), .tc(j_tc)
    );

    tile_loop_cnt #(.WIDTH(IDX_W)) u_cnt_k (
        .clk(clk), .reset(reset), .clear(cnt_clear), .en(k_en),
        .max_val(TILE_MAX), .count(k_cnt), .tc(k_tc)
    );

    tile_loop_cnt #(.WIDTH(R_W)) u_cnt_r (
        .clk(clk), .reset(reset), .clear(cnt_clear), .en(r_en),
        .max_val(r_max), .count(r_cnt), .tc(r_tc)
    );

    // Next-state and loop-counter enables. A stall freezes every phase
    // state, so counters and addresses hold as well.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        r_en      = 1'b0;
        k_en      = 1'b0;
        j_en      = 1'b0;
        i_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_LOAD_A;
                    cnt_clear = 1'b1;
                end
            end
            ST_LOAD_A: begin
                if (!stall) begin
                    r_en = 1'b1;
                    if (r_tc) begin
                        state_d = ST_LOAD_W;
                    end
                end
            end
            ST_LOAD_W: begin
                if (!stall) begin
                    r_en = 1'b1;
                    if (r_tc) begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (!stall) begin
                    r_en = 1'b1;
                    if (r_tc) begin
                        k_en    = 1'b1;
                        state_d = k_tc ? ST_DELOAD : ST_LOAD_A;
                    end
                end
            end
            ST_DELOAD: begin
                if (!stall) begin
                    r_en = 1'b1;
                    if (r_tc) begin
                        j_en    = 1'b1;
                        i_en    = j_tc;
                        state_d = (i_tc && j_tc) ? ST_DONE : ST_LOAD_A;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase strobes and status. The strobes drop while stalled so the array
    // never sees a repeated beat.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        load_a     = (state_q == ST_LOAD_A)  && !stall;
        load_w     = (state_q == ST_LOAD_W)  && !stall;
        compute    = (state_q == ST_COMPUTE) && !stall;
        deload_out = (state_q == ST_DELOAD)  && !stall;
        clear_acc  = (state_q == ST_LOAD_A) && !stall &&
                     (k_cnt == '0) && (r_cnt == '0);
    end

    // Buffer addresses follow the loop indices during their own phase.
    // Outside that phase they hold the last value issued.
    always_comb begin
        addr_a_d   = addr_a_q;
        addr_w_d   = addr_w_q;
        addr_res_d = addr_res_q;
        if (state_q == ST_LOAD_A) begin
            addr_a_d = ADDR_WIDTH'(tile_addr(32'(i_cnt), 32'(r_cnt), 32'(k_cnt),
                                             32'(ROW_A), 32'(T)));
        end
        if (state_q == ST_LOAD_W) begin
            addr_w_d = ADDR_WIDTH'(tile_addr(32'(k_cnt), 32'(r_cnt), 32'(j_cnt),
                                             32'(ROW_A), 32'(T)));
        end
        if (state_q == ST_DELOAD) begin
            addr_res_d = ADDR_WIDTH'(tile_addr(32'(i_cnt), 32'(r_cnt), 32'(j_cnt),
                                               32'(ROW_A), 32'(T)));
        end
    end

    assign addr_a   = addr_a_d;
    assign addr_w   = addr_w_d;
    assign addr_res = addr_res_d;

    assign index_i = i_cnt;
    assign index_j = j_cnt;
    assign index_k = k_cnt;
    assign index_r = IDX_W'(r_cnt);

    // State, start history and address hold registers. Reset sets the start
    // history to 1. A start held high through reset then has to drop before
    // it can launch a job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            addr_a_q     <= '0;
            addr_w_q     <= '0;
            addr_res_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            addr_a_q     <= addr_a_d;
            addr_w_q     <= addr_w_d;
            addr_res_q   <= addr_res_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cycle_count_q;
    logic [31:0] cycle_count_d;

    // Job length counter: cleared on launch, counts every busy cycle
    // including stalls, and holds once the job returns to idle.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (state_q == ST_IDLE) begin
            if (start_edge) begin
                cycle_count_d = '0;
            end
        end else begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    // Without the performance option there is no cycle counter.
`endif

endmodule

// File: tb/tb_tile_sched_ctrl.sv
// Directed testbench for tile_sched_ctrl with ROW_M=4 and ROW_A=2 (T=2).
// Cycle c of each scenario is the c-th clock period after the scenario
// starts. Start rises in cycle 0. Outputs are sampled on the falling edge.
module tb_tile_sched_ctrl;

    localparam int ROW_M      = 4;
    localparam int ROW_A      = 2;
    localparam int ADDR_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic                  load_a;
    logic                  load_w;
    logic                  compute;
    logic                  deload_out;
    logic                  clear_acc;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [ADDR_WIDTH-1:0] addr_res;
    logic [1:0]            index_i;
    logic [1:0]            index_j;
    logic [1:0]            index_k;
    logic [1:0]            index_r;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]           cycle_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    tile_sched_ctrl #(
        .ROW_M(ROW_M), .ROW_A(ROW_A), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy), .done(done), .load_a(load_a), .load_w(load_w),
        .compute(compute), .deload_out(deload_out), .clear_acc(clear_acc),
        .addr_a(addr_a), .addr_w(addr_w), .addr_res(addr_res),
        .index_i(index_i), .index_j(index_j), .index_k(index_k),
        .index_r(index_r)
`ifdef SCHED_PERF_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset state, with a stall in idle that must have no effect.
    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            stall = (c == 1 || c == 2);
            @(negedge clk);
            compared++;
            if ({busy, done} !== 2'b00) begin
                mismatched++;
                $display("[TB] FAIL reset_status c=%0d got %b want 00", c, {busy, done});
            end
            compared++;
            if ({load_a, load_w, compute, deload_out, clear_acc} !== 5'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_strobes c=%0d got %b want 00000", c,
                         {load_a, load_w, compute, deload_out, clear_acc});
            end
            compared++;
            if ({addr_a, addr_w, addr_res, index_i, index_j, index_k, index_r} !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_addr_idx c=%0d got %h want 0", c,
                         {addr_a, addr_w, addr_res, index_i, index_j, index_k, index_r});
            end
`ifdef SCHED_PERF_CNT_EN
            compared++;
            if (cycle_count !== 32'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_cycle_count got %0d want 0", cycle_count);
            end
`endif
            tick();
        end
        stall = 1'b0;
    endtask

    // Full job, checked beat by beat against a hand-derived phase table.
    // Each (i,j) block is 18 cycles long:
    //   offsets 0-1 LOAD_A, 2-3 LOAD_W, 4-7 COMPUTE  (k=0)
    //   offsets 8-9 LOAD_A, 10-11 LOAD_W, 12-15 COMPUTE (k=1)
    //   offsets 16-17 DELOAD
    task automatic test_full_job();
        int o, blk, ei, ej, ek, er, exp_addr, busy_cnt;
        logic [4:0] exp_strb;
        logic [7:0] exp_idx;
        logic [7:0] obs_addr;
        busy_cnt = 0;
        start = 1'b0;
        tick();
        for (int c = 0; c <= 80; c++) begin
            if (c == 0) start = 1'b1;
            if (c == 5) start = 1'b0;
            @(negedge clk);
            exp_strb = 5'b0;
            exp_idx  = 8'h0;
            exp_addr = -1;
            if (c >= 1 && c <= 72) begin
                o   = (c - 1) % 18;
                blk = (c - 1) / 18;
                ei  = blk / 2;
                ej  = blk % 2;
                if (o <= 1 || (o >= 8 && o <= 9)) begin
                    ek = (o >= 8) ? 1 : 0;
                    er = o % 2;
                    exp_strb = (o == 0) ? 5'b10001 : 5'b10000;
                    exp_addr = (ei * 2 + er) * 2 + ek;
                end else if (o <= 3 || (o >= 10 && o <= 11)) begin
                    ek = (o >= 10) ? 1 : 0;
                    er = o % 2;
                    exp_strb = 5'b01000;
                    exp_addr = (ek * 2 + er) * 2 + ej;
                end else if (o <= 15) begin
                    ek = (o >= 12) ? 1 : 0;
                    er = (o >= 12) ? o - 12 : o - 4;
                    exp_strb = 5'b00100;
                end else begin
                    ek = 0;
                    er = o - 16;
                    exp_strb = 5'b00010;
                    exp_addr = (ei * 2 + er) * 2 + ej;
                end
                exp_idx = {2'(ei), 2'(ej), 2'(ek), 2'(er)};
            end
            compared++;
            if ({load_a, load_w, compute, deload_out, clear_acc} !== exp_strb) begin
                mismatched++;
                $display("[TB] FAIL job_strobes c=%0d got %b want %b", c,
                         {load_a, load_w, compute, deload_out, clear_acc}, exp_strb);
            end
            compared++;
            if ({index_i, index_j, index_k, index_r} !== exp_idx) begin
                mismatched++;
                $display("[TB] FAIL job_indices c=%0d got %h want %h", c,
                         {index_i, index_j, index_k, index_r}, exp_idx);
            end
            if (exp_addr >= 0) begin
                obs_addr = exp_strb[4] ? addr_a : (exp_strb[3] ? addr_w : addr_res);
                compared++;
                if (obs_addr !== 8'(exp_addr)) begin
                    mismatched++;
                    $display("[TB] FAIL job_addr c=%0d got %0d want %0d", c, obs_addr, exp_addr);
                end
            end
            compared++;
            if ({busy, done} !== {(c >= 1 && c <= 73), (c == 73)}) begin
                mismatched++;
                $display("[TB] FAIL job_busy_done c=%0d got %b want %b", c, {busy, done},
                         {(c >= 1 && c <= 73), (c == 73)});
            end
            if (busy) busy_cnt++;
            if (c == 74) begin
                compared++;
                if ({addr_a, addr_w, addr_res} !== {8'd7, 8'd7, 8'd7}) begin
                    mismatched++;
                    $display("[TB] FAIL job_addr_hold got %0d/%0d/%0d want 7/7/7",
                             addr_a, addr_w, addr_res);
                end
            end
`ifdef SCHED_PERF_CNT_EN
            if (c == 75 || c == 80) begin
                compared++;
                if (cycle_count !== 32'd73) begin
                    mismatched++;
                    $display("[TB] FAIL job_cycle_count c=%0d got %0d want 73", c, cycle_count);
                end
            end
`endif
            tick();
        end
        compared++;
        if (busy_cnt !== 73) begin
            mismatched++;
            $display("[TB] FAIL job_busy_cycles got %0d want 73", busy_cnt);
        end
    endtask

    // Five-cycle stall in the first COMPUTE (beat 1): everything freezes,
    // and done slips from cycle 73 to cycle 78.
    task automatic test_stall();
        int done_cnt;
        done_cnt = 0;
        start = 1'b0;
        tick();
        for (int c = 0; c <= 85; c++) begin
            if (c == 0) start = 1'b1;
            if (c == 3) start = 1'b0;
            stall = (c >= 6 && c <= 10);
            @(negedge clk);
            if (done) done_cnt++;
            if (c >= 6 && c <= 10) begin
                compared++;
                if ({load_a, load_w, compute, deload_out, clear_acc} !== 5'b0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_strobes c=%0d got %b want 00000", c,
                             {load_a, load_w, compute, deload_out, clear_acc});
                end
                compared++;
                if ({busy, index_k, index_r, addr_a, addr_w} !== {1'b1, 2'd0, 2'd1, 8'd2, 8'd2}) begin
                    mismatched++;
                    $display("[TB] FAIL stall_frozen c=%0d got busy=%b k=%0d r=%0d a=%0d w=%0d want 1/0/1/2/2",
                             c, busy, index_k, index_r, addr_a, addr_w);
                end
            end
            if (c == 11 || c == 12) begin
                compared++;
                if ({compute, index_r} !== {1'b1, 2'(c - 10)}) begin
                    mismatched++;
                    $display("[TB] FAIL stall_resume c=%0d got compute=%b r=%0d want 1/%0d",
                             c, compute, index_r, c - 10);
                end
            end
            if (c == 73 || c == 78 || c == 79) begin
                compared++;
                if ({busy, done} !== {(c != 79), (c == 78)}) begin
                    mismatched++;
                    $display("[TB] FAIL stall_done_shift c=%0d got %b want %b", c,
                             {busy, done}, {(c != 79), (c == 78)});
                end
            end
            tick();
        end
        stall = 1'b0;
        compared++;
        if (done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL stall_done_count got %0d want 1", done_cnt);
        end
    endtask

    // Reset during LOAD_W with start held high and stall asserted. The job
    // aborts and does not relaunch until start goes low and then high again.
    task automatic test_reset_mid_job();
        start = 1'b0;
        tick();
        for (int c = 0; c <= 14; c++) begin
            if (c == 0)  start = 1'b1;
            if (c == 10) start = 1'b0;
            if (c == 11) start = 1'b1;
            reset = (c == 3 || c == 13);
            stall = (c == 3);
            @(negedge clk);
            if (c == 2 || c == 4) begin
                compared++;
                if ({load_a, addr_a} !== ((c == 2) ? {1'b1, 8'd2} : {1'b0, 8'd0})) begin
                    mismatched++;
                    $display("[TB] FAIL rst_load_a c=%0d got %b/%0d", c, load_a, addr_a);
                end
            end
            if (c >= 4 && c <= 11) begin
                compared++;
                if ({busy, done, load_a, load_w, compute, deload_out, clear_acc} !== 7'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rst_idle c=%0d got %b want 0000000", c,
                             {busy, done, load_a, load_w, compute, deload_out, clear_acc});
                end
                compared++;
                if ({addr_w, addr_res, index_i, index_j, index_k, index_r} !== 24'h0) begin
                    mismatched++;
                    $display("[TB] FAIL rst_zero c=%0d got %h want 0", c,
                             {addr_w, addr_res, index_i, index_j, index_k, index_r});
                end
            end
            if (c == 12) begin
                compared++;
                if ({busy, load_a, clear_acc} !== 3'b111) begin
                    mismatched++;
                    $display("[TB] FAIL rst_relaunch got %b want 111", {busy, load_a, clear_acc});
                end
            end
            if (c == 14) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rst_abort got busy=%b want 0", busy);
                end
            end
            tick();
        end
        reset = 1'b0;
        stall = 1'b0;
    endtask

    // A second start edge mid-job is ignored and done pulses exactly once.
    task automatic test_back_to_back();
        int done_cnt, busy_cnt;
        done_cnt = 0;
        busy_cnt = 0;
        start = 1'b0;
        tick();
        for (int c = 0; c <= 100; c++) begin
            if (c == 0)  start = 1'b1;
            if (c == 20) start = 1'b0;
            if (c == 22) start = 1'b1;
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (c == 73) begin
                compared++;
                if (done !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_done_at_73 got %b want 1", done);
                end
            end
            tick();
        end
        start = 1'b0;
        compared++;
        if (done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_count got %0d want 1", done_cnt);
        end
        compared++;
        if (busy_cnt !== 73) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy_cycles got %0d want 73", busy_cnt);
        end
    endtask

    // Apply reset, then run each scenario in turn and print the summary.
    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) tick();
        test_reset();
        test_full_job();
        test_stall();
        test_reset_mid_job();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tile_sched_ctrl.md
TILE_SCHED_CTRL -- requirements
Module: tile_sched_ctrl

Interface
REQ-001 Parameter ROW_M, default 8: square matrix dimension in elements.
REQ-002 Parameter ROW_A, default 4: systolic array dimension and tile edge; ROW_M SHALL be a multiple of ROW_A; T = ROW_M/ROW_A.
REQ-003 Parameter ADDR_WIDTH, default 8: buffer address width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  job request; launches a job on its rising edge.
REQ-007 stall  in  1  freezes the sequence while high.
REQ-008 busy / done  out  1 each  job in progress / one-cycle completion pulse.
REQ-009 load_a, load_w, compute, deload_out, clear_acc  out  1 each  phase strobes to the array.
REQ-010 addr_a, addr_w, addr_res  out  ADDR_WIDTH each  buffer addresses.
REQ-011 index_i, index_j, index_k, index_r  out  $clog2(ROW_M) each  tile row, tile column, reduction tile, beat within phase.

Function
REQ-012 FSM states: IDLE, LOAD_A, LOAD_W, COMPUTE, DELOAD, DONE.
- Loop order: i outer, j middle, k inner; each index runs 0..T-1.
REQ-013 IDLE->LOAD_A on cycle after start high with the previous-cycle start low; level-held start SHALL NOT relaunch.
REQ-014 LOAD_A: ROW_A cycles, load_a=1, addr_a = (i*ROW_A + r)*T + k, r = 0..ROW_A-1; then LOAD_W.
REQ-015 LOAD_W: ROW_A cycles, load_w=1, addr_w = (k*ROW_A + r)*T + j; then COMPUTE.
REQ-016 COMPUTE: 3*ROW_A-2 cycles, compute=1.
- Exit to LOAD_A with k+1 if k<T-1, else DELOAD.
REQ-017 DELOAD: ROW_A cycles, deload_out=1, addr_res = (i*ROW_A + r)*T + j.
- Exit: next (i,j) via LOAD_A with k=0; j wraps to 0 and increments i; after (T-1,T-1) go to DONE.
REQ-018 clear_acc SHALL pulse one cycle coincident with the first LOAD_A beat of k=0 for every (i,j).
REQ-019 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-020 Exactly one of load_a/load_w/compute/deload_out SHALL be high in active non-stalled cycles; all low in IDLE, DONE and while stall=1.
REQ-021 stall=1 SHALL hold state, all counters and addresses unchanged; stall in IDLE is ignored; start edges during a job are ignored.
REQ-022 Addresses are truncated to ADDR_WIDTH.
- Addresses outside their phase hold their last value.
REQ-023 Total non-stalled job length SHALL be T*T*(T*(5*ROW_A-2) + ROW_A) cycles from LOAD_A entry to DONE entry.

Reset
REQ-024 reset SHALL force IDLE and zero all counters, indices, addresses and outputs on the next edge, overriding stall and start, including mid-job.
REQ-025 After reset, start held high SHALL NOT launch until it is seen low then high.

Configuration
REQ-026 Macro SCHED_PERF_CNT_EN defined: add output cycle_count (32 bits).
- Cleared at launch; increments every busy cycle, stalled cycles included.
- Holds after done; zeroed by reset.
REQ-027 SCHED_PERF_CNT_EN undefined: no cycle_count port and no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package config_sys.vh holds ROW_M, ROW_A, ADDR_WIDTH defaults and FSM state encodings.
REQ-029 One sub-module, tile_loop_cnt: a wrapping counter with enable, terminal-count flag and sync clear, instantiated for i, j, k and r.

Verification
REQ-030 ROW_M=4, ROW_A=2, start rising at cycle 0 -> LOAD_A at cycle 1, done=1 at cycle 73, busy=1 cycles 1..73.
REQ-031 Same config, first (i,j)=(0,0) -> addr_a 0,2 (k=0) then 1,3 (k=1); addr_w 0,2 then 4,6; addr_res 0,2; clear_acc once at cycle 1.
REQ-032 stall=1 for 5 cycles mid-COMPUTE -> strobes low, all outputs frozen; done moves to cycle 78.
REQ-033 reset=1 mid-LOAD_W with start held high -> IDLE next cycle, all outputs 0; no relaunch until start toggles low then high.
REQ-034 Second start edge during a job -> ignored, done pulses exactly once.
REQ-035 SCHED_PERF_CNT_EN defined, run of REQ-030 -> cycle_count = 73 after done, held while idle.
